// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the WB stage and the MDU, with a
// starvation guard that requests a pipeline bubble and a destination scoreboard.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_OUT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wd,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_wd,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ok,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        stall_req,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt, wait_inc;
  logic        stall_nxt;
  logic [31:0] pending, pending_nxt;
  logic [1:0]  count;
  logic        pipe_act, mdu_acc, issue_acc;

  assign pipe_act  = pipe_we && (pipe_rd != 5'd0);
  assign mdu_ready = !pipe_act;
  assign mdu_acc   = mdu_valid && mdu_ready;
  assign issue_ok  = (count < MAX_CNT);
  assign issue_acc = issue_valid && issue_ok;
  assign rs1_busy  = pending[rs1_addr];
  assign rs2_busy  = pending[rs2_addr];
  assign wait_inc  = wait_cnt + 4'd1;

  always_comb begin
    WE3 = 1'b0;
    A3  = 5'd0;
    WD3 = 32'd0;
    if (rst) begin
      if (pipe_act) begin
        WE3 = 1'b1;
        A3  = pipe_rd;
        WD3 = pipe_wd;
      end else if (mdu_valid) begin
        WE3 = (mdu_rd != 5'd0);
        A3  = mdu_rd;
        WD3 = mdu_wd;
      end
    end
  end

  // IDLE counts the first blocked cycle as 1, so the same limit test serves both states
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stall_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (mdu_valid && pipe_act) begin
          if (LIMIT == 4'd1) begin
            state_nxt    = STALL;
            wait_cnt_nxt = 4'd0;
            stall_nxt    = 1'b1;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 4'd1;
          end
        end
      end
      WAIT: begin
        if (!mdu_valid || mdu_acc) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 4'd0;
        end else if (wait_inc == LIMIT) begin
          state_nxt    = STALL;
          wait_cnt_nxt = 4'd0;
          stall_nxt    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_inc;
        end
      end
      STALL: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 4'd0;
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      stall_req <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      stall_req <= stall_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) proto_err <= 1'b0;
    else if (stall_req && pipe_we) proto_err <= 1'b1;
  end

  // clear first so a same-cycle issue to the same register wins
  always_comb begin
    pending_nxt = pending;
    if (mdu_acc && (mdu_rd != 5'd0)) pending_nxt[mdu_rd] = 1'b0;
    if (issue_acc && (issue_rd != 5'd0)) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= 32'd0;
    else pending <= pending_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
    end else begin
      case ({issue_acc, mdu_acc})
        2'b10:   count <= count + 2'd1;
        2'b01:   if (count != 2'd0) count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and a long-latency multiply/divide unit (MDU). The pipeline always wins a write cycle. The MDU writes in idle slots, and a starvation guard forces a pipeline bubble when the MDU has waited too long. A destination scoreboard tracks registers with MDU results outstanding so the hazard unit can stall dependent instructions. The block sits between the WB stage, the MDU and the register file write port (WE3/A3/WD3).

## Interface
- STARVE_LIMIT, 4: consecutive blocked MDU cycles before a bubble is requested (1..15).
- MAX_OUT, 2: maximum MDU operations in flight (1..3).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pipe_we  in  1  WB stage write request.
- pipe_rd  in  5  WB destination register.
- pipe_wd  in  32  WB write data.
- mdu_valid  in  1  MDU result available.
- mdu_rd  in  5  MDU destination register.
- mdu_wd  in  32  MDU result data.
- mdu_ready  out  1  MDU result accepted this cycle when mdu_valid=1.
- issue_valid  in  1  decode issues an MDU op this cycle.
- issue_rd  in  5  destination of the issued MDU op.
- issue_ok  out  1  an MDU op may be issued (outstanding < MAX_OUT).
- rs1_addr, rs2_addr  in  5 each  decode source registers.
- rs1_busy, rs2_busy  out  1 each  source has a pending MDU write.
- stall_req  out  1  registered; pipeline must present pipe_we=0 in the following cycle.
- WE3  out  1  register file write enable.
- A3  out  5  register file write address.
- WD3  out  32  register file write data.
- proto_err  out  1  sticky; pipe_we=1 seen while stall_req=1.

## Operation
- pipe_act = pipe_we && pipe_rd!=0. mdu_ready = !pipe_act.
- Write port is combinational:
  - If pipe_act: WE3=1, A3=pipe_rd, WD3=pipe_wd.
  - Else if mdu_valid: WE3=(mdu_rd!=0), A3=mdu_rd, WD3=mdu_wd.
  - Else WE3=0, A3=0, WD3=0.
  - All three outputs are forced to 0 while rst=0.
- An MDU write to x0 completes the handshake but does not write.
- FSM states:
  - IDLE: if mdu_valid && pipe_act, go to WAIT and set wait_cnt=1.
  - WAIT: accept (mdu_valid && !pipe_act) goes to IDLE. Otherwise wait_cnt increments. When the increment reaches STARVE_LIMIT, go to STALL and register stall_req=1.
  - STALL: stall_req=1 for exactly one cycle. The MDU is granted in that cycle. Return to IDLE. If mdu_valid dropped, return to IDLE with no write.
  - If mdu_valid deasserts in WAIT, go to IDLE and clear wait_cnt.
- If pipe_we=1 while stall_req=1, the pipeline still wins the port and proto_err is set. proto_err clears only on reset.
- Scoreboard, pending[31:1]:
  - Set on issue_valid && issue_ok && issue_rd!=0.
  - Cleared on an MDU accept for mdu_rd.
  - Same register set and cleared in one cycle: set wins.
  - pending[0] is constant 0.
- rsN_busy = pending[rsN_addr], combinational. An MDU accept in the current cycle does not clear busy until the next cycle.
- Outstanding counter, 2 bits:
  - +1 on an accepted issue, −1 on an MDU accept, unchanged when both occur.
  - issue_ok = (count < MAX_OUT).
  - issue_valid with issue_ok=0 is ignored.

## Timing
- Write latency: 0 cycles from request to WE3. The register file captures the write at the next rising edge.
- MDU accept with no pipeline conflict takes 0 wait cycles.
- Worst-case MDU wait: STARVE_LIMIT blocked cycles, plus 1 stall_req cycle in which the write is made.
- stall_req is a flop output, asserted the cycle after the limit is reached, high for 1 cycle.
- Reset values (rst=0, asynchronous): state=IDLE, wait_cnt=0, stall_req=0, pending=0, count=0, proto_err=0.
  - With rst=0: issue_ok=1, rsN_busy=0, WE3=0, A3=0, WD3=0.
  - mdu_ready follows pipe_act.
- Reset asserted mid-WAIT or mid-STALL aborts immediately. An in-flight MDU result is not written.
- The first edge after rst deasserts operates normally.

## Test plan
- **No conflict:** mdu_valid=1, mdu_rd=7, mdu_wd=0xDEADBEEF, pipe_we=0, with pending[7] set → same cycle mdu_ready=1, WE3=1, A3=7. Next cycle rs1_busy(rs1_addr=7)=0 and count decremented.
- **Starvation (STARVE_LIMIT=4):** pipe_we=1 to x5 for 6 cycles while mdu_valid=1 to x9 → the pipeline writes x5 for 4 cycles. stall_req=1 in cycle 5 with pipe_we held at 0, and x9 is written then. Later stall_req=0 and state=IDLE.
- **Scoreboard limits (MAX_OUT=2):** issue x3, then x4 → issue_ok=0. A third issue to x6 is ignored and rs1_busy(x6)=0. An MDU accept for x3 → issue_ok=1 next cycle.
- **Simultaneous issue and complete on x8:** issue x8 in the same cycle as an MDU accept for x8 → pending[8]=1 afterwards, count unchanged.
- **x0 handling:** pipe_we=1 with pipe_rd=0 and mdu_valid=1 → the MDU is granted. An MDU result to x0 → mdu_ready=1, WE3=0. issue_rd=0 → no pending bit set.
- **Reset in WAIT, and protocol error:**
  - Drop rst to 0 during WAIT → immediately stall_req=0, WE3=0, pending=0.
  - Separately, pipe_we=1 during stall_req=1 → proto_err=1, held until reset.
